seq_mult_rca: RTL

- Sequential shift-and-add unsigned multiplier, N x N -> 2N bits.
- One partial-product add per clock, performed by a single instance of the existing N-bit ripple-carry adder.
- Sits directly downstream of that adder in the datapath: supplies its operands each cycle, then registers and consumes its Sum/Cout.
- Start/busy/done handshake towards the controlling logic.

---
 rtl/seq_mult_rca_pkg.sv | 9 +
 rtl/seq_mult_rca_adder.sv | 18 +
 rtl/seq_mult_rca.sv | 85 ++++++++
 3 files changed

// File: rtl/seq_mult_rca_pkg.sv
// seq_mult_rca_pkg: shared state encoding and default width for the shift-and-add multiplier
package seq_mult_rca_pkg;
  localparam int MULT_N = 6;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/seq_mult_rca_adder.sv
// seq_mult_rca_adder: N-bit ripple-carry adder, sum_o/cout_o = p_i + q_i + cin_i
module seq_mult_rca_adder #(
  parameter int N = 6
) (
  input  logic [N-1:0] p_i,
  input  logic [N-1:0] q_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:0] c;
  assign c[0] = cin_i;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = p_i[i] ^ q_i[i] ^ c[i];
    assign c[i+1]   = (p_i[i] & q_i[i]) | (c[i] & (p_i[i] ^ q_i[i]));
  end
  assign cout_o = c[N];
endmodule

// File: rtl/seq_mult_rca.sv
// seq_mult_rca: sequential N x N -> 2N unsigned shift-and-add multiplier, one adder pass per clock
//   clk, rst_n (async active-low); start/a/b request; busy in RUN, done one-cycle pulse; product holds last result
module seq_mult_rca
  import seq_mult_rca_pkg::*;
#(
  parameter int N  = MULT_N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d, acc_q, acc_d, q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic [N-1:0]     sum;
  logic             cout;
  logic [N-1:0]     s;
  logic             c;
  logic [2*N-1:0]   shifted;
  seq_mult_rca_adder #(.N(N)) u_adder (
    .p_i   (acc_q),
    .q_i   (m_q),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(cout)
  );
  // Add only when the current multiplier bit is set; the carry becomes the new top bit.
  assign {c, s}  = q_q[0] ? {cout, sum} : {1'b0, acc_q};
  assign shifted = {c, s, q_q[N-1:1]};
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? RUN : IDLE;
        if (start) begin
          m_d   = a;
          q_d   = b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      RUN: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          prod_d  = shifted;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign product = prod_q;
endmodule
